serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock. It uses a DIGIT-bit ripple slice built from one-bit full-adder cells. The block is the sequential, handshaked successor to the team's single-bit full adder. It serves lab datapaths that trade latency for area, and it also serves as a carry-chain reference for later ALU work.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be at least 2.
- DIGIT, 1, bits added per cycle; WIDTH must be an integer multiple of DIGIT.
- Derived constant N = WIDTH/DIGIT: the number of RUN cycles per addition.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new addition; sampled only when busy=0.
- a  input  WIDTH  operand A; latched when start is accepted.
- b  input  WIDTH  operand B; latched when start is accepted.
- cin  input  1  carry-in; latched when start is accepted.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse: sum/cout/ovf are valid and new.
- sum  output  WIDTH  result (a+b+cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, internal shift registers=0. Takes effect immediately regardless of clk.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, exactly one cycle.
- Start acceptance: start is accepted at a rising edge where state is IDLE or DONE and start=1.
  - Operands go into shift registers sa/sb; carry register takes cin; counter goes to 0; state becomes RUN.
- Start during RUN is ignored: no latch, no queue, no error.
- RUN, each edge:
  - Low DIGIT bits of sa, sb and the carry register feed the ripple slice.
  - Slice result is shifted into the top of the sum register, LSB digit first.
  - sa and sb shift right by DIGIT; carry register takes the slice carry-out; counter increments.
- On the RUN edge where counter==N-1:
  - Final digit is processed; state becomes DONE.
  - cout = final slice carry-out.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. The slice exposes its internal carry into its top bit for this.
- Latency: start accepted at edge k, done=1 during the cycle after edge k+N. busy=1 for exactly N cycles.
- DONE to IDLE on the next edge unless a new start is accepted; back-to-back starts give no idle cycle.
- sum/cout/ovf hold their values from DONE until the next accepted start. The sum register may show partial values during RUN; consumers must qualify with done.
- Wrap-around: sum is modulo 2^WIDTH; cout carries the lost bit. WIDTH=DIGIT (N=1) is legal and gives a one-cycle add.
- Reset mid-RUN aborts the addition. No done pulse is produced; all outputs clear as for reset.

Decomposition:
- Package serial_adder_pkg holds the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a clog2-based counter-width function.
- Sub-module fa_slice: purely combinational DIGIT-bit ripple chain of one-bit full-adder cells.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, c_msb_in (carry into its top bit).
- All sequencing stays in serial_adder.

Test Plan:
- WIDTH=8, DIGIT=1: start with a=0x5A, b=0x3C, cin=0. Expect done exactly 8 cycles after the accepting edge with sum=0x96, cout=0, ovf=1, and busy high for exactly 8 cycles.
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 gives sum=0x00, cout=1, ovf=0. Then a=0x80, b=0x80, cin=1 gives sum=0x01, cout=1, ovf=1.
- WIDTH=8, DIGIT=4: a=0x7F, b=0x00, cin=1. Expect done 2 cycles after start with sum=0x80, cout=0, ovf=1.
  - Also pulse start=1 with a=0x11 during RUN. Expect it ignored and the result unchanged.
- Back-to-back:
  - Assert start in the DONE cycle with a=0x03, b=0x04. Expect busy=1 next cycle, no IDLE cycle, and a second done with sum=0x07.
  - Previous sum stays visible until that accept edge.
- Reset mid-operation: assert rst asynchronously (between edges) 3 cycles into RUN. Expect all outputs 0 immediately, no done pulse, and state IDLE.
  - After release, a fresh start with a=0x01, b=0x01 yields sum=0x02.
- Exhaustive check at WIDTH=4, DIGIT=1 and at WIDTH=4, DIGIT=2: all 512 (a, b, cin) combinations compared against a+b+cin for sum, cout and ovf. This extends the bit-level full-adder truth table.

Source files
------------

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_pkg
// Purpose  : State encoding and sizing helper shared by the serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bits needed for a counter running 0..n-1. Never returns less than one
    // bit, so a single-digit adder still has a legal counter vector.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_fa_slice.sv
`default_nettype none
// ============================================================================
// Module   : fa_slice
// Purpose  : Combinational DIGIT-bit ripple chain of one-bit full adders.
//            Also exposes the carry entering its top bit, which lets the
//            sequencer derive two's-complement overflow on the last digit.
// Revision : 1.0 - initial release
// ============================================================================
module fa_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic carry;

    // Ripple the carry through one full-adder cell per bit, LSB first
    always_comb begin
        s        = '0;
        carry    = ci;
        c_msb_in = ci;
        for (int i = 0; i < DIGIT; i++) begin
            c_msb_in = carry;
            s[i]     = x[i] ^ y[i] ^ carry;
            carry    = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        co = carry;
    end

endmodule : fa_slice
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Handshaked multi-cycle adder. Adds WIDTH-bit a + b + cin,
//            DIGIT bits per clock, producing sum, carry-out and signed
//            overflow with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] sa_q,    sa_d;
    logic [WIDTH-1:0] sb_q,    sb_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;

    logic [DIGIT-1:0] slice_s;
    logic             slice_co;
    logic             slice_cmsb;
    logic [WIDTH-1:0] sum_shift;

    fa_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .x        (sa_q[DIGIT-1:0]),
        .y        (sb_q[DIGIT-1:0]),
        .ci       (carry_q),
        .s        (slice_s),
        .co       (slice_co),
        .c_msb_in (slice_cmsb)
    );

    // New digit enters at the top; after N shifts the first digit sits at
    // the LSB. A single-digit adder has nothing to shift down.
    if (WIDTH == DIGIT) begin : g_single
        assign sum_shift = slice_s;
    end else begin : g_multi
        assign sum_shift = {slice_s, sum_q[WIDTH-1:DIGIT]};
    end

    // Next-state logic: accept in IDLE/DONE, one digit per RUN cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d   = sum_shift;
                sa_d    = sa_q >> DIGIT;
                sb_d    = sb_q >> DIGIT;
                carry_d = slice_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cout_d  = slice_co;
                    ovf_d   = slice_cmsb ^ slice_co;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Directed self-checking bench for serial_adder in four
//            configurations: 8/1, 8/4, 4/1 and 4/2 (WIDTH/DIGIT).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic [3:0] start_v;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;

    int n_assert;
    int n_fail;

    logic       busy0, busy1, busy2, busy3;
    logic       done0, done1, done2, done3;
    logic       cout0, cout1, cout2, cout3;
    logic       ovf0,  ovf1,  ovf2,  ovf3;
    logic [7:0] sum0,  sum1;
    logic [3:0] sum2,  sum3;

    logic       busy_v [4];
    logic       done_v [4];
    logic       cout_v [4];
    logic       ovf_v  [4];
    logic [7:0] sum_v  [4];

    assign busy_v = '{busy0, busy1, busy2, busy3};
    assign done_v = '{done0, done1, done2, done3};
    assign cout_v = '{cout0, cout1, cout2, cout3};
    assign ovf_v  = '{ovf0,  ovf1,  ovf2,  ovf3};
    assign sum_v  = '{sum0,  sum1,  {4'h0, sum2}, {4'h0, sum3}};

    serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .cin(cin),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));

    serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

    serial_adder #(.WIDTH(4), .DIGIT(1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a[3:0]), .b(b[3:0]), .cin(cin),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

    serial_adder #(.WIDTH(4), .DIGIT(2)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .a(a[3:0]), .b(b[3:0]), .cin(cin),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input int u, input string tag);
        chk({tag, " busy"}, 8'(busy_v[u]), 8'd0);
        chk({tag, " done"}, 8'(done_v[u]), 8'd0);
        chk({tag, " sum"},  sum_v[u],      8'd0);
        chk({tag, " cout"}, 8'(cout_v[u]), 8'd0);
        chk({tag, " ovf"},  8'(ovf_v[u]),  8'd0);
    endtask

    // Drive start for one edge, then expect busy for n cycles and a done
    // pulse carrying the expected result. Returns in the DONE cycle.
    task automatic do_add(input int u, input logic [7:0] aa, input logic [7:0] bb,
                          input logic cc, input int n, input logic [7:0] es,
                          input logic ec, input logic eo, input string tag);
        a = aa; b = bb; cin = cc;
        start_v[u] = 1'b1;
        @(posedge clk); #1;
        start_v[u] = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy"}, 8'(busy_v[u]), 8'd1);
            chk({tag, " no-done"}, 8'(done_v[u]), 8'd0);
            @(posedge clk); #1;
        end
        chk({tag, " done"}, 8'(done_v[u]), 8'd1);
        chk({tag, " busy-low"}, 8'(busy_v[u]), 8'd0);
        chk({tag, " sum"}, sum_v[u], es);
        chk({tag, " cout"}, 8'(cout_v[u]), 8'(ec));
        chk({tag, " ovf"}, 8'(ovf_v[u]), 8'(eo));
    endtask

    initial begin
        logic [4:0] t;
        logic [3:0] xa, xb;
        logic       eo;
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start_v  = 4'h0;
        a = 8'h00; b = 8'h00; cin = 1'b0;

        // Reset state of every instance
        #1;
        for (int u = 0; u < 4; u++) chk_all_zero(u, "reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // 8/1: basic add with signed overflow, then one idle cycle
        do_add(0, 8'h5A, 8'h3C, 1'b0, 8, 8'h96, 1'b0, 1'b1, "5A+3C");
        @(posedge clk); #1;
        chk("idle busy", 8'(busy0), 8'd0);
        chk("idle done", 8'(done0), 8'd0);
        chk("idle hold sum", sum0, 8'h96);
        chk("idle hold ovf", 8'(ovf0), 8'd1);

        // 8/1: wrap-around, then back-to-back starts in the DONE cycle
        do_add(0, 8'hFF, 8'h01, 1'b0, 8, 8'h00, 1'b1, 1'b0, "FF+01");
        do_add(0, 8'h80, 8'h80, 1'b1, 8, 8'h01, 1'b1, 1'b1, "80+80+1");
        a = 8'h03; b = 8'h04;
        chk("b2b prev sum", sum0, 8'h01);
        do_add(0, 8'h03, 8'h04, 1'b0, 8, 8'h07, 1'b0, 1'b0, "b2b 03+04");

        // 8/4: two-cycle add with a start pulse during RUN that must be ignored
        a = 8'h7F; b = 8'h00; cin = 1'b1;
        start_v[1] = 1'b1;
        @(posedge clk); #1;
        chk("d4 busy0", 8'(busy1), 8'd1);
        a = 8'h11; b = 8'h22; cin = 1'b0;
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        chk("d4 busy1", 8'(busy1), 8'd1);
        chk("d4 no-done", 8'(done1), 8'd0);
        @(posedge clk); #1;
        chk("d4 done", 8'(done1), 8'd1);
        chk("d4 sum", sum1, 8'h80);
        chk("d4 cout", 8'(cout1), 8'd0);
        chk("d4 ovf", 8'(ovf1), 8'd1);
        @(posedge clk); #1;
        chk("d4 idle busy", 8'(busy1), 8'd0);
        chk("d4 idle done", 8'(done1), 8'd0);
        chk("d4 idle sum", sum1, 8'h80);

        // 8/1: asynchronous reset 3 cycles into RUN aborts the addition
        a = 8'h12; b = 8'h34; cin = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("pre-rst busy", 8'(busy0), 8'd1);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero(0, "async rst");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("in-rst done", 8'(done0), 8'd0);
            chk("in-rst busy", 8'(busy0), 8'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-rst idle", 8'(busy0), 8'd0);
        chk("post-rst no-done", 8'(done0), 8'd0);
        do_add(0, 8'h01, 8'h01, 1'b0, 8, 8'h02, 1'b0, 1'b0, "post-rst 01+01");

        // Exhaustive 4-bit checks against an arithmetic reference
        for (int u = 2; u < 4; u++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    for (int c = 0; c < 2; c++) begin
                        xa = 4'(x);
                        xb = 4'(y);
                        t  = {1'b0, xa} + {1'b0, xb} + 5'(c);
                        eo = (xa[3] == xb[3]) && (t[3] != xa[3]);
                        do_add(u, {4'h0, xa}, {4'h0, xb}, 1'(c), (u == 2) ? 4 : 2,
                               {4'h0, t[3:0]}, t[4], eo, (u == 2) ? "x4d1" : "x4d2");
                    end
                end
            end
        end

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
